// File: rtl/psram_resp_pkg.sv
// Shared constants for the HyperRAM responder: FSM encodings, CA bit positions,
// the CR0 reset value and the initial-latency decode helpers.
package psram_resp_pkg;

    localparam logic [15:0] CR0_RESET_DEF = 16'h8F1F;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CA      = 3'd1;
    localparam logic [2:0] ST_LAT     = 3'd2;
    localparam logic [2:0] ST_READ    = 3'd3;
    localparam logic [2:0] ST_WRITE   = 3'd4;
    localparam logic [2:0] ST_WAIT_CS = 3'd5;

    // Bit positions inside the 48-bit command/address word.
    localparam int CA_RW_BIT = 47;
    localparam int CA_AS_BIT = 46;
    localparam int CA_ROW_HI = 33;
    localparam int CA_ROW_LO = 16;
    localparam int CA_COL_W  = 3;

    function automatic logic [3:0] lat_decode(input logic [3:0] code);
        logic [3:0] lat;
        case (code)
            4'b1110: lat = 4'd3;
            4'b1111: lat = 4'd4;
            4'b0000: lat = 4'd5;
            4'b0001: lat = 4'd6;
            default: lat = 4'd6;
        endcase
        return lat;
    endfunction

    // ck_idx of the first data beat: 2 + L, or 2 + 2L when doubled.
    function automatic logic [7:0] first_idx(input logic x2, input logic [3:0] code);
        logic [3:0] lat;
        logic [7:0] idx;
        lat = lat_decode(code);
        if (x2) begin
            idx = 8'd2 + {3'd0, lat, 1'b0};
        end else begin
            idx = 8'd2 + {4'd0, lat};
        end
        return idx;
    endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// Word array behind the responder: per-byte write enables and a registered
// read port (read data appears the cycle after raddr is presented).
module psram_resp_mem
    import psram_resp_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_hi,
    input  logic          we_lo,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [2**AW];
    logic [15:0] rdata_q;

    // Byte-masked array write; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_hi) begin
            mem_q[waddr][15:8] <= wdata[15:8];
        end
        if (we_lo) begin
            mem_q[waddr][7:0] <= wdata[7:0];
        end
    end

    // Synchronous read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 16'h0000;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/psram_responder.sv
// Cycle-level HyperRAM target on the single-clock DDR-split view (rising/falling byte per clk).
// Optional: define PSRAM_RESP_LFSR_EN to force 2x latency pseudo-randomly per transaction.
module psram_responder
    import psram_resp_pkg::*;
#(
    parameter int          MEM_AW    = 12,
    parameter logic [15:0] CR0_RESET = CR0_RESET_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        ck_e,
    input  logic [7:0]  dq_in_ris,
    input  logic [7:0]  dq_in_fal,
    input  logic        rwds_in_ris,
    input  logic        rwds_in_fal,
    input  logic        force_2x,
    output logic [7:0]  dq_out_ris,
    output logic [7:0]  dq_out_fal,
    output logic        dq_oe,
    output logic        rwds_out_ris,
    output logic        rwds_out_fal,
    output logic        rwds_oe,
    output logic [15:0] cfg_reg,
    output logic        lat2x
);

    logic [2:0]        state_q, state_d, st_eff_s;
    logic [7:0]        ck_idx_q, ck_idx_d;
    logic              is_read_q, is_read_d;
    logic              is_reg_q, is_reg_d;
    logic              lat2x_q, lat2x_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [15:0]       cfg_q, cfg_d;
    logic              dq_oe_q, dq_oe_d;
    logic              rwds_oe_q, rwds_oe_d;
    logic              rwds_ris_q, rwds_ris_d;
    logic              rwds_fal_q, rwds_fal_d;
    logic [7:0]        d_idx_s, d_idx_nx_s;
    logic              beat_s, we_hi_s, we_lo_s, lfsr_hit_s;
    logic [15:0]       in_word_s, rdata_s, rd_word_s;

    assign beat_s    = ck_e & ~cs_n;
    assign in_word_s = {dq_in_ris, dq_in_fal};
    // A CA beat may coincide with the cs_n falling edge, so IDLE behaves as CA then.
    assign st_eff_s  = (state_q == ST_IDLE && !cs_n) ? ST_CA : state_q;
    assign d_idx_s   = first_idx(lat2x_q, cfg_q[7:4]);

`ifdef PSRAM_RESP_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4, stepping once per transaction start.
    always_comb begin
        if (state_q == ST_IDLE && !cs_n) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_hit_s = (lfsr_q[2:0] == 3'd0);
`else
    assign lfsr_hit_s = 1'b0;
`endif

    // Transaction FSM, CA decode and array/register access control.
    always_comb begin
        state_d   = state_q;
        ck_idx_d  = ck_idx_q;
        is_read_d = is_read_q;
        is_reg_d  = is_reg_q;
        lat2x_d   = lat2x_q;
        addr_d    = addr_q;
        cfg_d     = cfg_q;
        we_hi_s   = 1'b0;
        we_lo_s   = 1'b0;
        if (cs_n) begin
            state_d  = ST_IDLE;
            ck_idx_d = 8'd0;
        end else begin
            if (state_q == ST_IDLE) begin
                lat2x_d = force_2x | cfg_q[3] | lfsr_hit_s;
            end else begin
                lat2x_d = lat2x_q;
            end
            if (beat_s) begin
                ck_idx_d = (ck_idx_q == 8'hFF) ? ck_idx_q : ck_idx_q + 8'd1;
            end else begin
                ck_idx_d = ck_idx_q;
            end
            state_d = st_eff_s;
            case (st_eff_s)
                ST_CA: begin
                    if (beat_s) begin
                        // Address bits are shifted in MSB-first; the top ones fall off at MEM_AW.
                        case (ck_idx_q)
                            8'd0: begin
                                is_read_d = dq_in_ris[CA_RW_BIT - 40];
                                is_reg_d  = dq_in_ris[CA_AS_BIT - 40];
                                addr_d    = {MEM_AW{1'b0}};
                                for (int i = CA_ROW_HI - 32; i >= 0; i--) begin
                                    addr_d = {addr_d[MEM_AW-2:0], dq_in_fal[i[2:0]]};
                                end
                            end
                            8'd1: begin
                                for (int i = 31 - CA_ROW_LO; i >= 0; i--) begin
                                    addr_d = {addr_d[MEM_AW-2:0], in_word_s[i[3:0]]};
                                end
                            end
                            8'd2: begin
                                for (int i = CA_COL_W - 1; i >= 0; i--) begin
                                    addr_d = {addr_d[MEM_AW-2:0], dq_in_fal[i[2:0]]};
                                end
                                state_d = ST_LAT;
                            end
                            default: state_d = ST_WAIT_CS;
                        endcase
                    end else begin
                        state_d = ST_CA;
                    end
                end
                ST_LAT: begin
                    if (beat_s) begin
                        if (is_reg_q && !is_read_q) begin
                            cfg_d   = in_word_s;
                            state_d = ST_WAIT_CS;
                        end else if (ck_idx_q == d_idx_s - 8'd1) begin
                            state_d = is_read_q ? ST_READ : ST_WRITE;
                        end else begin
                            state_d = ST_LAT;
                        end
                    end else begin
                        state_d = ST_LAT;
                    end
                end
                ST_READ: begin
                    if (beat_s) begin
                        addr_d = addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
                    end else begin
                        addr_d = addr_q;
                    end
                end
                ST_WRITE: begin
                    if (beat_s) begin
                        we_hi_s = ~rwds_in_ris;
                        we_lo_s = ~rwds_in_fal;
                        addr_d  = addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
                    end else begin
                        addr_d = addr_q;
                    end
                end
                ST_WAIT_CS: state_d = ST_WAIT_CS;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    assign d_idx_nx_s = first_idx(lat2x_d, cfg_d[7:4]);

    // Output drive derived from the next state so the flops present it in that state.
    always_comb begin
        dq_oe_d    = 1'b0;
        rwds_oe_d  = 1'b0;
        rwds_ris_d = 1'b0;
        rwds_fal_d = 1'b0;
        case (state_d)
            ST_CA: begin
                rwds_oe_d  = 1'b1;
                rwds_ris_d = lat2x_d;
                rwds_fal_d = lat2x_d;
            end
            ST_LAT: begin
                if (is_read_d) begin
                    rwds_oe_d = 1'b1;
                end else if (is_reg_d) begin
                    rwds_oe_d = 1'b0;
                end else begin
                    rwds_oe_d = (ck_idx_d < d_idx_nx_s - 8'd1);
                end
            end
            ST_READ: begin
                dq_oe_d    = 1'b1;
                rwds_oe_d  = 1'b1;
                rwds_ris_d = 1'b1;
                rwds_fal_d = 1'b0;
            end
            default: begin
                dq_oe_d   = 1'b0;
                rwds_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ck_idx_q   <= 8'd0;
            is_read_q  <= 1'b0;
            is_reg_q   <= 1'b0;
            lat2x_q    <= 1'b0;
            addr_q     <= {MEM_AW{1'b0}};
            cfg_q      <= CR0_RESET;
            dq_oe_q    <= 1'b0;
            rwds_oe_q  <= 1'b0;
            rwds_ris_q <= 1'b0;
            rwds_fal_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ck_idx_q   <= ck_idx_d;
            is_read_q  <= is_read_d;
            is_reg_q   <= is_reg_d;
            lat2x_q    <= lat2x_d;
            addr_q     <= addr_d;
            cfg_q      <= cfg_d;
            dq_oe_q    <= dq_oe_d;
            rwds_oe_q  <= rwds_oe_d;
            rwds_ris_q <= rwds_ris_d;
            rwds_fal_q <= rwds_fal_d;
        end
    end

    // Read address runs one word ahead so the registered array output matches addr_q.
    psram_resp_mem #(.AW(MEM_AW)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we_hi (we_hi_s),
        .we_lo (we_lo_s),
        .waddr (addr_q),
        .wdata (in_word_s),
        .raddr (addr_d),
        .rdata (rdata_s)
    );

    assign rd_word_s    = is_reg_q ? cfg_q : rdata_s;
    assign dq_out_ris   = dq_oe_q ? rd_word_s[15:8] : 8'h00;
    assign dq_out_fal   = dq_oe_q ? rd_word_s[7:0] : 8'h00;
    assign dq_oe        = dq_oe_q;
    assign rwds_oe      = rwds_oe_q;
    assign rwds_out_ris = rwds_ris_q;
    assign rwds_out_fal = rwds_fal_q;
    assign cfg_reg      = cfg_q;
    assign lat2x        = lat2x_q;

endmodule
